mac_ofm_packer: RTL
===================

Name: mac_ofm_packer

Overview:
Downstream stage of a MAC lane. Consumes the per-lane 32-bit result stream (mac_lane_ofm_port) and keeps only final results (accum_end=1), dropping partial sums. Packs PACK_N final words into one wide beat, buffers beats in a small FIFO, and presents them with valid/ready to the output writeback path.

Parameters:
PACK_N, 4, final words per output beat (power of 2, >=2)
FIFO_DEPTH, 4, output beat FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_ofm_valid  in  1  input word valid
i_ofm  in  33  mac_lane_ofm_port {data[31:0], accum_end}
o_ofm_ready  out  1  input word accepted when valid&ready
i_flush  in  1  level request to emit the partial pack; hold until o_flush_ack
o_flush_ack  out  1  flush taken this cycle
o_pack_valid  out  1  output beat valid
o_pack_data  out  PACK_N*32  word k at bits [32k+31:32k], k=0 is first accepted
o_pack_keep  out  PACK_N  per-word valid mask
o_pack_last  out  1  beat closed by a flush
i_pack_ready  in  1  downstream accepts beat

Behaviour:
- Reset (async, rst=1): pack count=0, pack regs=0, FIFO empty. o_pack_valid=0, o_pack_data=0, o_pack_keep=0, o_pack_last=0, o_flush_ack=0. o_ofm_ready=1 once FIFO is empty. Reset mid-operation discards all buffered words and beats.
- o_ofm_ready = !fifo_full, combinational from registered FIFO state only.
- Accepted word with accum_end=0: discarded, no state change.
- Accepted word with accum_end=1: stored at slot cnt, cnt++.
- When cnt reaches PACK_N, the beat {data, keep=all ones, last=0} is written to the FIFO at that same edge and cnt returns to 0. o_pack_valid rises the next cycle, so latency is 1 cycle from accepting the last word to output valid.
- o_flush_ack = i_flush & !fifo_full (combinational).
- On flush_ack with cnt>0: beat {data, keep=(1<<cnt)-1, last=1} written. Unused slots are zero. cnt is set to 0.
- On flush_ack with cnt=0: no beat is written. Ack still pulses.
- Flush in the same cycle as an accepted final word: the word is included first, then the pack is emitted with last=1. If that word fills the pack, keep is all ones and last=1, and only one beat is written.
- Output handshake: a beat pops on o_pack_valid & i_pack_ready.
  - o_pack_* hold stable while valid & !ready.
  - A FIFO push and pop in the same cycle are both legal when full. o_ofm_ready still evaluates to 0 that cycle (no bypass).
- No word is ever lost or duplicated. The input is stalled only when the FIFO is full.

Optional Feature:
MAC_OFM_MONITOR_EN
- Defined: adds input i_fp_mode (1 = results are FP32), input i_monitor_clr, and output o_monitor (mac_lane_monitor).
  - On each accepted final word with i_fp_mode=1: exp==8'hFF & mant!=0 sets sticky is_nan; exp==8'hFF & mant==0 sets sticky is_inf.
  - i_monitor_clr clears both flags next edge. A set in the same cycle wins over clear.
  - Flags reset to 0.
- Undefined: these ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared mac_pkg additions:
  - MAC_W_OFM=32.
  - typedef mac_ofm_pack_beat (packed {data, keep, last}), parameterised by a package constant MAC_OFM_PACK_N=4 that is used as the PACK_N default.
- Sub-module mac_ofm_fifo: synchronous FIFO, width = beat width, depth FIFO_DEPTH, with full/empty and registered read data. The top level holds the pack counter, pack registers, flush and monitor logic.

Test Plan:
- Send 4 finals 0x11,0x22,0x33,0x44 with ready=1 -> one beat data=0x00000044_00000033_00000022_00000011, keep=4'b1111, last=0, valid 1 cycle after 4th accept.
- Interleave partials (accum_end=0) 0xDEAD between finals 1..4 -> same single beat; no 0xDEAD present.
- 3 finals 0xA,0xB,0xC then i_flush -> ack same cycle; beat keep=4'b0111, last=1, word3=0. Flush with cnt=0 -> ack, no beat.
- i_pack_ready=0, stream 20 finals -> exactly 4 beats buffered, o_ofm_ready=0 after the 16th accept. Release ready -> 5 beats in order, data intact.
- Assert rst mid-stream with 2 words packed and 2 beats queued -> outputs 0 immediately. After release, 4 new finals give a single beat with only the new data.
- With MAC_OFM_MONITOR_EN and i_fp_mode=1: final 0x7FC00000 -> is_nan=1; final 0xFF800000 -> is_inf=1. i_monitor_clr -> both 0. With i_fp_mode=0, 0x7FC00000 -> flags stay 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC lane types: result word, monitor flags and packed output beat.
package mac_pkg;

   localparam int unsigned MAC_W_OFM      = 32;
   localparam int unsigned MAC_OFM_PACK_N = 4;
   localparam int unsigned MAC_FP_EXP_W   = 8;
   localparam int unsigned MAC_FP_MANT_W  = 23;

   typedef struct packed {
      logic [MAC_W_OFM-1:0] data;
      logic                 accum_end;
   } mac_lane_ofm_port;

   typedef struct packed {
      logic is_nan;
      logic is_inf;
   } mac_lane_monitor;

   typedef struct packed {
      logic [MAC_OFM_PACK_N*MAC_W_OFM-1:0] data;
      logic [MAC_OFM_PACK_N-1:0]           keep;
      logic                                last;
   } mac_ofm_pack_beat;

   // FP32 special-value classification, returns {is_nan, is_inf}
   function automatic logic [1:0] fp32_class(input logic [MAC_W_OFM-1:0] w);
      logic [MAC_FP_EXP_W-1:0]  exp_f;
      logic [MAC_FP_MANT_W-1:0] mant_f;
      exp_f  = w[MAC_FP_MANT_W +: MAC_FP_EXP_W];
      mant_f = w[MAC_FP_MANT_W-1:0];
      fp32_class = {(&exp_f) && (|mant_f), (&exp_f) && !(|mant_f)};
   endfunction

endpackage

// File: rtl/mac_ofm_fifo.sv
// Synchronous beat FIFO with registered head-of-queue read data and flags.
module mac_ofm_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_n;
   logic [CW-1:0]    survivors;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      pop_ok    = i_pop & !o_empty;
      push_ok   = i_push & (!o_full | pop_ok);
      survivors = count - CW'(pop_ok);
      count_n   = survivors + CW'(push_ok);
      rd_ptr_n  = rd_ptr + AW'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= i_wdata;
   end

   // Head register takes the incoming beat when nothing older survives the pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         o_full  <= 1'b0;
         o_empty <= 1'b1;
         o_rdata <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_n;
         count   <= count_n;
         o_full  <= (count_n == CW'(DEPTH));
         o_empty <= (count_n == '0);
         if (count_n != '0) o_rdata <= (survivors == '0) ? i_wdata : mem[rd_ptr_n];
      end
   end

endmodule

// File: rtl/mac_ofm_packer.sv
// Packs final MAC lane results into PACK_N-word beats behind a small FIFO.
// Optional FP32 NaN/Inf sticky monitor enabled by MAC_OFM_MONITOR_EN.
module mac_ofm_packer
   import mac_pkg::*;
#(
   parameter int unsigned PACK_N     = MAC_OFM_PACK_N,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_ofm_valid,
   input  mac_lane_ofm_port              i_ofm,
   output logic                          o_ofm_ready,
   input  logic                          i_flush,
   output logic                          o_flush_ack,
   output logic                          o_pack_valid,
   output logic [PACK_N*MAC_W_OFM-1:0]   o_pack_data,
   output logic [PACK_N-1:0]             o_pack_keep,
   output logic                          o_pack_last,
   input  logic                          i_pack_ready
`ifdef MAC_OFM_MONITOR_EN
   ,
   input  logic                          i_fp_mode,
   input  logic                          i_monitor_clr,
   output mac_lane_monitor               o_monitor
`endif
);

   localparam int unsigned DATA_W = PACK_N * MAC_W_OFM;
   localparam int unsigned CNT_W  = $clog2(PACK_N + 1);
   localparam int unsigned IDX_W  = $clog2(PACK_N);
   localparam int unsigned BEAT_W = DATA_W + PACK_N + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PACK_N-1:0] keep;
      logic              last;
   } beat_t;

   logic [CNT_W-1:0]                  cnt;
   logic [CNT_W-1:0]                  cnt_after;
   logic [PACK_N-1:0][MAC_W_OFM-1:0]  pack_q;
   logic [PACK_N-1:0][MAC_W_OFM-1:0]  pack_after;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic                              fin;
   logic                              push;
   beat_t                             wr_beat;
   beat_t                             rd_beat;
   logic [BEAT_W-1:0]                 rd_raw;

   assign o_ofm_ready = !fifo_full;
   assign o_flush_ack = i_flush & !fifo_full;
   assign fin         = i_ofm_valid & o_ofm_ready & i_ofm.accum_end;

   // Fold the accepted word in first, then decide whether a beat closes
   always_comb begin
      pack_after = pack_q;
      cnt_after  = cnt;
      if (fin) begin
         pack_after[cnt[IDX_W-1:0]] = i_ofm.data;
         cnt_after                  = cnt + CNT_W'(1);
      end
      push         = (cnt_after == CNT_W'(PACK_N)) | (o_flush_ack & (cnt_after != '0));
      wr_beat.data = pack_after;
      wr_beat.last = o_flush_ack;
      for (int unsigned k = 0; k < PACK_N; k++) begin
         wr_beat.keep[k] = (CNT_W'(k) < cnt_after);
      end
   end

   // Slots are cleared on emit so a partial beat carries zeros in unused words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         pack_q <= '0;
      end else if (push) begin
         cnt    <= '0;
         pack_q <= '0;
      end else begin
         cnt    <= cnt_after;
         pack_q <= pack_after;
      end
   end

   mac_ofm_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push),
      .i_wdata (wr_beat),
      .i_pop   (i_pack_ready),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_rdata (rd_raw)
   );

   assign rd_beat      = rd_raw;
   assign o_pack_valid = !fifo_empty;
   assign o_pack_data  = rd_beat.data;
   assign o_pack_keep  = rd_beat.keep;
   assign o_pack_last  = rd_beat.last;

`ifdef MAC_OFM_MONITOR_EN
   logic [1:0] cls;
   logic       set_nan;
   logic       set_inf;

   always_comb begin
      cls     = fp32_class(i_ofm.data);
      set_nan = fin & i_fp_mode & cls[1];
      set_inf = fin & i_fp_mode & cls[0];
   end

   // Sticky flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_monitor <= '0;
      end else begin
         o_monitor.is_nan <= (o_monitor.is_nan & !i_monitor_clr) | set_nan;
         o_monitor.is_inf <= (o_monitor.is_inf & !i_monitor_clr) | set_inf;
      end
   end
`endif

endmodule
